// File: rtl/grf_write_arb.sv
// grf_write_arb: GRF write-port arbiter. Each cycle one write is chosen for the
// registered write port: the pipeline writeback when present, else the head of a
// small FIFO of auxiliary (multi-cycle unit) writes. The decode-stage hazard flag
// is raised while a source register is still waiting in that FIFO.
// Optional macro GRF_WRITE_TRACE_EN: prints one line per issued write.
module grf_write_arb #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_valid,
    input  logic [31:0] i_wb_pc,
    input  logic [4:0]  i_wb_reg,
    input  logic [31:0] i_wb_data,
    input  logic        i_aux_valid,
    output logic        o_aux_ready,
    input  logic [31:0] i_aux_pc,
    input  logic [4:0]  i_aux_reg,
    input  logic [31:0] i_aux_data,
    input  logic [4:0]  i_rd_reg1,
    input  logic [4:0]  i_rd_reg2,
    output logic        o_rd_hazard,
    output logic        o_we,
    output logic [31:0] o_w_pc,
    output logic [4:0]  o_w_reg,
    output logic [31:0] o_w_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [31:0]   r_pc   [DEPTH];
    logic [4:0]    r_reg  [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_rptr, r_wptr;
    logic [CW-1:0] r_count;

    logic          r_we;
    logic [31:0]   r_wpc;
    logic [4:0]    r_wreg;
    logic [31:0]   r_wdata;

    logic          w_push, w_pop;

    // Ready depends on the current occupancy only, so a same-cycle pop never
    // opens a slot for a push into a full FIFO. Register-0 aux writes shake
    // hands but are dropped; the head is popped only when wb is idle.
    assign o_aux_ready = !reset && (r_count < CW'(DEPTH));
    assign w_push      = i_aux_valid && o_aux_ready && (i_aux_reg != 5'd0);
    assign w_pop       = !reset && !i_wb_valid && (r_count != '0);

    // Hazard scan: an entry is live when its distance from the read pointer is
    // below the count; the head being popped this cycle is still live.
    always_comb begin
        logic [AW-1:0] off;
        o_rd_hazard = 1'b0;
        off         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - r_rptr;
            if ((CW'(off) < r_count) &&
                (((i_rd_reg1 != 5'd0) && (r_reg[i] == i_rd_reg1)) ||
                 ((i_rd_reg2 != 5'd0) && (r_reg[i] == i_rd_reg2))))
                o_rd_hazard = 1'b1;
        end
    end

    // FIFO storage: written on push, contents need no reset (guarded by count).
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_wptr]   <= i_aux_pc;
            r_reg[r_wptr]  <= i_aux_reg;
            r_data[r_wptr] <= i_aux_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    // Registered write port: wb first, then FIFO head, else no write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_wpc   <= '0;
            r_wreg  <= '0;
            r_wdata <= '0;
        end else if (i_wb_valid) begin
            r_we    <= 1'b1;
            r_wpc   <= i_wb_pc;
            r_wreg  <= i_wb_reg;
            r_wdata <= i_wb_data;
        end else if (w_pop) begin
            r_we    <= 1'b1;
            r_wpc   <= r_pc[r_rptr];
            r_wreg  <= r_reg[r_rptr];
            r_wdata <= r_data[r_rptr];
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign o_we     = r_we;
    assign o_w_pc   = r_wpc;
    assign o_w_reg  = r_wreg;
    assign o_w_data = r_wdata;

`ifdef GRF_WRITE_TRACE_EN
    // Trace every write presented on the port, register 0 included.
    always_ff @(posedge clk) begin
        if (!reset && r_we)
            $display("@%08h: $%0d <= %08h", r_wpc, r_wreg, r_wdata);
    end
`else
`endif

endmodule

// File: tb/tb_grf_write_arb.sv
// Bench for grf_write_arb: a directed vector table, then hand sequences and
// random traffic checked against a queue-based reference model.
module tb_grf_write_arb;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, aux_valid, aux_ready, rd_hazard, we;
    logic [31:0] wb_pc, wb_data, aux_pc, aux_data, w_pc, w_data;
    logic [4:0]  wb_reg, aux_reg, rd_reg1, rd_reg2, w_reg;

    int total = 0;
    int bad   = 0;

    grf_write_arb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .i_wb_valid(wb_valid), .i_wb_pc(wb_pc), .i_wb_reg(wb_reg), .i_wb_data(wb_data),
        .i_aux_valid(aux_valid), .o_aux_ready(aux_ready),
        .i_aux_pc(aux_pc), .i_aux_reg(aux_reg), .i_aux_data(aux_data),
        .i_rd_reg1(rd_reg1), .i_rd_reg2(rd_reg2), .o_rd_hazard(rd_hazard),
        .o_we(we), .o_w_pc(w_pc), .o_w_reg(w_reg), .o_w_data(w_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic wbv, input logic [31:0] wpc,
                         input logic [4:0] wreg, input logic [31:0] wdat,
                         input logic av, input logic [31:0] apc, input logic [4:0] areg,
                         input logic [31:0] adat, input logic [4:0] r1, input logic [4:0] r2);
        reset = rst; wb_valid = wbv; wb_pc = wpc; wb_reg = wreg; wb_data = wdat;
        aux_valid = av; aux_pc = apc; aux_reg = areg; aux_data = adat;
        rd_reg1 = r1; rd_reg2 = r2;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic rst, wbv; logic [4:0] wreg; logic [31:0] wdat;
        logic av; logic [4:0] areg; logic [31:0] adat; logic [4:0] rd1;
        logic e_rdy, e_haz, e_we; logic [4:0] e_reg; logic [31:0] e_dat, e_pc;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic wbv, input logic [4:0] wreg,
                                input logic [31:0] wdat, input logic av, input logic [4:0] areg,
                                input logic [31:0] adat, input logic [4:0] rd1,
                                input logic e_rdy, input logic e_haz, input logic e_we,
                                input logic [4:0] e_reg, input logic [31:0] e_dat,
                                input logic [31:0] e_pc);
        vec_t v;
        v.rst = rst; v.wbv = wbv; v.wreg = wreg; v.wdat = wdat; v.av = av; v.areg = areg;
        v.adat = adat; v.rd1 = rd1; v.e_rdy = e_rdy; v.e_haz = e_haz; v.e_we = e_we;
        v.e_reg = e_reg; v.e_dat = e_dat; v.e_pc = e_pc;
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] pc; logic [4:0] r; logic [31:0] d; } ent_t;
    ent_t        q[$];
    logic [31:0] m_pc, m_dat;
    logic [4:0]  m_reg;

    task automatic step(input logic rst, input logic wbv, input logic [31:0] wpc,
                        input logic [4:0] wreg, input logic [31:0] wdat,
                        input logic av, input logic [31:0] apc, input logic [4:0] areg,
                        input logic [31:0] adat, input logic [4:0] r1, input logic [4:0] r2);
        logic e_rdy, e_haz, e_we;
        ent_t h;
        drive(rst, wbv, wpc, wreg, wdat, av, apc, areg, adat, r1, r2);
        e_rdy = !rst && (q.size() < DEPTH);
        e_haz = 1'b0;
        foreach (q[i])
            if ((r1 != 0 && q[i].r == r1) || (r2 != 0 && q[i].r == r2)) e_haz = 1'b1;
        #1;
        check("m_aux_ready", {31'd0, aux_ready}, {31'd0, e_rdy});
        check("m_rd_hazard", {31'd0, rd_hazard}, {31'd0, e_haz});
        e_we = 1'b0;
        if (rst) begin
            q.delete();
            m_pc = 0; m_reg = 0; m_dat = 0;
        end else begin
            if (wbv) begin
                e_we = 1'b1; m_pc = wpc; m_reg = wreg; m_dat = wdat;
            end else if (q.size() > 0) begin
                h = q.pop_front();
                e_we = 1'b1; m_pc = h.pc; m_reg = h.r; m_dat = h.d;
            end
            if (av && e_rdy && areg != 0) begin
                h.pc = apc; h.r = areg; h.d = adat;
                q.push_back(h);
            end
        end
        @(posedge clk); #1;
        check("m_we", {31'd0, we}, {31'd0, e_we});
        if (e_we || rst) begin
            check("m_w_reg", {27'd0, w_reg}, {27'd0, m_reg});
            check("m_w_data", w_data, m_dat);
            check("m_w_pc", w_pc, m_pc);
        end
    endtask

    initial begin
        vec_t tbl[$];
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        //           rst wbv wreg wdat   av areg adat  rd1 rdy haz we reg  dat    pc
        tbl.push_back(mk(1, 0,  0, 0,     0,  0, 0,     0, 0, 0, 0,  0, 0,     0));
        tbl.push_back(mk(0, 0,  0, 0,     0,  0, 0,     0, 1, 0, 0,  0, 0,     0));
        tbl.push_back(mk(0, 1,  8, 'h11,  1,  9, 'h22,  0, 1, 0, 1,  8, 'h11,  'h3000));
        tbl.push_back(mk(0, 0,  0, 0,     0,  0, 0,     9, 1, 1, 1,  9, 'h22,  'h3004));
        tbl.push_back(mk(0, 0,  0, 0,     0,  0, 0,     9, 1, 0, 0,  0, 0,     0));
        tbl.push_back(mk(0, 0,  0, 0,     1,  5, 'h55,  0, 1, 0, 0,  0, 0,     0));
        tbl.push_back(mk(0, 0,  0, 0,     0,  0, 0,     5, 1, 1, 1,  5, 'h55,  'h3004));
        tbl.push_back(mk(0, 0,  0, 0,     0,  0, 0,     5, 1, 0, 0,  0, 0,     0));
        tbl.push_back(mk(0, 0,  0, 0,     1,  0, 'h99,  0, 1, 0, 0,  0, 0,     0));
        tbl.push_back(mk(0, 0,  0, 0,     0,  0, 0,     0, 1, 0, 0,  0, 0,     0));
        tbl.push_back(mk(0, 0,  0, 0,     0,  0, 0,     0, 1, 0, 0,  0, 0,     0));
        tbl.push_back(mk(0, 1, 20, 'hA0,  1,  1, 'h01,  0, 1, 0, 1, 20, 'hA0,  'h3000));
        tbl.push_back(mk(0, 1, 21, 'hA1,  1,  2, 'h02,  1, 1, 1, 1, 21, 'hA1,  'h3000));
        tbl.push_back(mk(0, 1, 22, 'hA2,  1,  3, 'h03,  0, 1, 0, 1, 22, 'hA2,  'h3000));
        tbl.push_back(mk(0, 1, 23, 'hA3,  1,  4, 'h04,  1, 1, 1, 1, 23, 'hA3,  'h3000));
        tbl.push_back(mk(0, 1, 24, 'hA4,  1,  7, 'h07,  4, 0, 1, 1, 24, 'hA4,  'h3000));
        tbl.push_back(mk(0, 0,  0, 0,     0,  0, 0,     7, 0, 0, 1,  1, 'h01,  'h3004));
        tbl.push_back(mk(0, 0,  0, 0,     0,  0, 0,     0, 1, 0, 1,  2, 'h02,  'h3004));
        tbl.push_back(mk(0, 0,  0, 0,     0,  0, 0,     0, 1, 0, 1,  3, 'h03,  'h3004));
        tbl.push_back(mk(0, 0,  0, 0,     0,  0, 0,     0, 1, 0, 1,  4, 'h04,  'h3004));
        tbl.push_back(mk(0, 0,  0, 0,     0,  0, 0,     7, 1, 0, 0,  0, 0,     0));
        tbl.push_back(mk(0, 1, 30, 'hB0,  1, 10, 'h0A,  0, 1, 0, 1, 30, 'hB0,  'h3000));
        tbl.push_back(mk(0, 1, 30, 'hB0,  1, 11, 'h0B,  0, 1, 0, 1, 30, 'hB0,  'h3000));
        tbl.push_back(mk(0, 1, 30, 'hB0,  1, 12, 'h0C,  0, 1, 0, 1, 30, 'hB0,  'h3000));
        tbl.push_back(mk(1, 1, 31, 'hEE,  1, 13, 'h0D,  0, 0, 0, 0,  0, 0,     0));
        tbl.push_back(mk(0, 0,  0, 0,     0,  0, 0,    10, 1, 0, 0,  0, 0,     0));
        tbl.push_back(mk(0, 0,  0, 0,     0,  0, 0,    11, 1, 0, 0,  0, 0,     0));
        tbl.push_back(mk(0, 0,  0, 0,     0,  0, 0,    12, 1, 0, 0,  0, 0,     0));

        @(posedge clk); #1;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].wbv, 32'h3000, tbl[i].wreg, tbl[i].wdat,
                  tbl[i].av, 32'h3004, tbl[i].areg, tbl[i].adat, tbl[i].rd1, 5'd0);
            #1;
            check($sformatf("t%0d_aux_ready", i), {31'd0, aux_ready}, {31'd0, tbl[i].e_rdy});
            check($sformatf("t%0d_rd_hazard", i), {31'd0, rd_hazard}, {31'd0, tbl[i].e_haz});
            @(posedge clk); #1;
            check($sformatf("t%0d_we", i), {31'd0, we}, {31'd0, tbl[i].e_we});
            if (tbl[i].e_we || tbl[i].rst) begin
                check($sformatf("t%0d_w_reg", i), {27'd0, w_reg}, {27'd0, tbl[i].e_reg});
                check($sformatf("t%0d_w_data", i), w_data, tbl[i].e_dat);
                check($sformatf("t%0d_w_pc", i), w_pc, tbl[i].e_pc);
            end
        end

        // Model-checked phase: reset, fill with wb held, then 8 push/pop pairs
        // that wrap the pointers while issuing in order.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++)
            step(0, 1, 32'h5000 + k, 5'd16 + 5'(k), 32'hC0 + k, 1, 32'h6000 + k, 5'(k), 32'hD0 + k, 5'(k), 0);
        step(0, 1, 32'h5005, 5'd21, 32'hC5, 1, 32'h6005, 5'd9, 32'hD5, 5'd9, 5'd4);
        for (int k = 0; k < 8; k++)
            step(0, 0, 0, 0, 0, 1, 32'h7000 + k, 5'd5 + 5'(k), 32'hE0 + k, 5'd5 + 5'(k), 5'd1);
        for (int k = 0; k < 6; k++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'(k + 9), 0);

        // Random traffic; small register range keeps hazard hits frequent.
        for (int n = 0; n < 2000; n++)
            step(($urandom_range(99) == 0), ($urandom_range(9) < 4), $urandom, 5'($urandom_range(7)),
                 $urandom, ($urandom_range(9) < 6), $urandom, 5'($urandom_range(7)), $urandom,
                 5'($urandom_range(7)), 5'($urandom_range(7)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
